// File: rtl/ahb_si_arbiter.sv
// Round-robin AHB arbiter for one slave-interface port: address-phase grant,
// registered data-phase select, burst/INCR/lock grant holding.
module ahb_si_arbiter #(
  parameter int unsigned CHANNEL_NUM    = 7,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned IDX_W          = $clog2(CHANNEL_NUM)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [CHANNEL_NUM-1:0] lock,
  input  logic                   hready,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  output logic [CHANNEL_NUM-1:0] addr_sel,
  output logic [CHANNEL_NUM-1:0] data_sel,
  output logic [IDX_W-1:0]       hmaster
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [IDX_W-1:0]       DEF_IDX = IDX_W'(DEFAULT_MASTER);
  localparam logic [CHANNEL_NUM-1:0] DEF_SEL = CHANNEL_NUM'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_BURST,
    ST_INCR,
    ST_LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;
  logic                   rearb;

  // Round-robin search starting just after rr_ptr, rr_ptr itself checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    cand      = '0;
    for (int unsigned i = 1; i <= CHANNEL_NUM; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % CHANNEL_NUM);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Transfer-boundary decode; nothing moves unless hready is high.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    hmaster_d  = hmaster_q;
    addr_sel_d = addr_sel_q;
    data_sel_d = data_sel_q;
    rearb      = 1'b0;

    if (hready) begin
      data_sel_d = htrans[1] ? addr_sel_q : '0;
      if (lock[hmaster_q]) begin
        state_d = ST_LOCKED;
      end else begin
        case (htrans)
          HT_NONSEQ: begin
            case (hburst)
              3'b000: begin
                beat_cnt_d = '0;
                state_d    = ST_ARB;
                rearb      = 1'b1;
              end
              3'b001: begin
                beat_cnt_d = '0;
                state_d    = ST_INCR;
              end
              3'b010, 3'b011: begin
                beat_cnt_d = CNT_W'(3);
                state_d    = ST_BURST;
              end
              3'b100, 3'b101: begin
                beat_cnt_d = CNT_W'(7);
                state_d    = ST_BURST;
              end
              default: begin
                beat_cnt_d = CNT_W'(15);
                state_d    = ST_BURST;
              end
            endcase
          end
          HT_SEQ: begin
            if (state_q == ST_BURST) begin
              if (beat_cnt_q <= CNT_W'(1)) begin
                beat_cnt_d = '0;
                state_d    = ST_ARB;
                rearb      = 1'b1;
              end else begin
                beat_cnt_d = beat_cnt_q - CNT_W'(1);
              end
            end else if (state_q == ST_INCR && !req[hmaster_q]) begin
              state_d = ST_ARB;
              rearb   = 1'b1;
            end else if (state_q == ST_LOCKED) begin
              state_d = ST_ARB;
            end
          end
          HT_BUSY: begin
            if (state_q == ST_INCR && !req[hmaster_q]) begin
              state_d = ST_ARB;
              rearb   = 1'b1;
            end else if (state_q == ST_LOCKED) begin
              state_d = ST_ARB;
            end
          end
          default: begin
            beat_cnt_d = '0;
            state_d    = ST_ARB;
            rearb      = 1'b1;
          end
        endcase
      end

      if (rearb) begin
        hmaster_d  = win_idx;
        addr_sel_d = CHANNEL_NUM'(1) << win_idx;
        if (win_found) rr_ptr_d = win_idx;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_ARB;
      beat_cnt_q <= '0;
      rr_ptr_q   <= DEF_IDX;
      hmaster_q  <= DEF_IDX;
      addr_sel_q <= DEF_SEL;
      data_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hmaster_q  <= hmaster_d;
      addr_sel_q <= addr_sel_d;
      data_sel_q <= data_sel_d;
    end
  end

  assign addr_sel = addr_sel_q;
  assign data_sel = data_sel_q;
  assign hmaster  = hmaster_q;

endmodule

// File: tb/tb_ahb_si_arbiter.sv
// Directed self-checking bench for ahb_si_arbiter (7 channels, default master 0).
module tb_ahb_si_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [6:0] req, lock;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic [6:0] addr_sel, data_sel;
  logic [2:0] hmaster;

  int nvec = 0;
  int nerr = 0;

  ahb_si_arbiter #(.CHANNEL_NUM(7), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset), .req(req), .lock(lock), .hready(hready),
    .htrans(htrans), .hburst(hburst), .addr_sel(addr_sel), .data_sel(data_sel),
    .hmaster(hmaster)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1; req = '0; lock = '0; hready = 1'b1; htrans = IDLE; hburst = 3'b000;
    step();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (addr_sel !== 7'b0000001 || hmaster !== 3'd0 || data_sel !== 7'b0) begin
      $display("FAIL reset: addr_sel=%b hmaster=%0d data_sel=%b exp 0000001/0/0000000",
               addr_sel, hmaster, data_sel);
      nerr++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (addr_sel !== 7'b0000001 || hmaster !== 3'd0 || data_sel !== 7'b0) begin
        $display("FAIL idle_hold[%0d]: addr_sel=%b hmaster=%0d data_sel=%b exp 0000001/0/0000000",
                 i, addr_sel, hmaster, data_sel);
        nerr++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_hm [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic [2:0] prev_hm;
    logic [6:0] exp_ds, exp_as;
    do_reset();
    prev_hm = 3'd0;
    req = 7'b0000110; htrans = NSEQ; hburst = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_ds = 7'b0000001 << prev_hm;
      exp_as = 7'b0000001 << exp_hm[i];
      nvec++;
      if (hmaster !== exp_hm[i] || addr_sel !== exp_as || data_sel !== exp_ds) begin
        $display("FAIL rr[%0d]: hmaster=%0d addr_sel=%b data_sel=%b exp %0d/%b/%b",
                 i, hmaster, addr_sel, data_sel, exp_hm[i], exp_as, exp_ds);
        nerr++;
      end
      prev_hm = exp_hm[i];
    end
  endtask

  task automatic test_fixed_burst();
    logic [1:0] tr   [7] = '{IDLE, NSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       rdy  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] ehm  [7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
    logic [6:0] eds  [7] = '{7'b0, 7'b0001000, 7'b0001000, 7'b0001000,
                             7'b0001000, 7'b0001000, 7'b0001000};
    do_reset();
    req = 7'b0001000; hburst = 3'b011;
    for (int i = 0; i < 7; i++) begin
      htrans = tr[i]; hready = rdy[i];
      if (i == 1) req = 7'b0101000;
      step();
      nvec++;
      if (hmaster !== ehm[i] || addr_sel !== (7'b0000001 << ehm[i]) || data_sel !== eds[i]) begin
        $display("FAIL incr4[%0d]: hmaster=%0d addr_sel=%b data_sel=%b exp hmaster %0d data_sel %b",
                 i, hmaster, addr_sel, data_sel, ehm[i], eds[i]);
        nerr++;
      end
    end
    hready = 1'b1;
  endtask

  task automatic test_incr_busy();
    logic [1:0] tr  [6] = '{IDLE, NSEQ, BUSY, SEQ, BUSY, SEQ};
    logic [6:0] rq  [6] = '{7'b0000100, 7'b0001100, 7'b0001100, 7'b0001100,
                            7'b0001100, 7'b0001000};
    logic [2:0] ehm [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [6:0] eds [6] = '{7'b0, 7'b0000100, 7'b0, 7'b0000100, 7'b0, 7'b0000100};
    do_reset();
    hburst = 3'b001;
    for (int i = 0; i < 6; i++) begin
      htrans = tr[i]; req = rq[i];
      step();
      nvec++;
      if (hmaster !== ehm[i] || addr_sel !== (7'b0000001 << ehm[i]) || data_sel !== eds[i]) begin
        $display("FAIL incr_busy[%0d]: hmaster=%0d addr_sel=%b data_sel=%b exp hmaster %0d data_sel %b",
                 i, hmaster, addr_sel, data_sel, ehm[i], eds[i]);
        nerr++;
      end
    end
  endtask

  task automatic test_locked();
    do_reset();
    req = 7'b0010000; htrans = IDLE;
    step();
    nvec++;
    if (hmaster !== 3'd4) begin
      $display("FAIL lock_setup: hmaster=%0d exp 4", hmaster);
      nerr++;
    end
    req = 7'b1111111; lock = 7'b0010000; htrans = NSEQ; hburst = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (hmaster !== 3'd4 || addr_sel !== 7'b0010000) begin
        $display("FAIL lock_hold[%0d]: hmaster=%0d addr_sel=%b exp 4/0010000", i, hmaster, addr_sel);
        nerr++;
      end
    end
    lock = '0; htrans = IDLE;
    step();
    nvec++;
    if (hmaster !== 3'd5 || addr_sel !== 7'b0100000) begin
      $display("FAIL lock_release: hmaster=%0d addr_sel=%b exp 5/0100000", hmaster, addr_sel);
      nerr++;
    end
  endtask

  task automatic test_early_term();
    do_reset();
    req = 7'b0000011; htrans = NSEQ; hburst = 3'b010;
    step();
    htrans = SEQ;
    step();
    nvec++;
    if (hmaster !== 3'd0) begin
      $display("FAIL early_hold: hmaster=%0d exp 0", hmaster);
      nerr++;
    end
    htrans = NSEQ; hburst = 3'b000;
    step();
    nvec++;
    if (hmaster !== 3'd1 || data_sel !== 7'b0000001) begin
      $display("FAIL early_term: hmaster=%0d data_sel=%b exp 1/0000001", hmaster, data_sel);
      nerr++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 7'b1000000; htrans = IDLE;
    step();
    htrans = NSEQ; hburst = 3'b100;
    step();
    htrans = SEQ;
    step();
    nvec++;
    if (hmaster !== 3'd6 || data_sel !== 7'b1000000) begin
      $display("FAIL wrap8_pre: hmaster=%0d data_sel=%b exp 6/1000000", hmaster, data_sel);
      nerr++;
    end
    hreset = 1'b1; hready = 1'b0;
    step();
    nvec++;
    if (addr_sel !== 7'b0000001 || hmaster !== 3'd0 || data_sel !== 7'b0) begin
      $display("FAIL mid_reset: addr_sel=%b hmaster=%0d data_sel=%b exp 0000001/0/0000000",
               addr_sel, hmaster, data_sel);
      nerr++;
    end
    hreset = 1'b0; hready = 1'b1; req = 7'b0000010; htrans = NSEQ; hburst = 3'b000;
    step();
    nvec++;
    if (hmaster !== 3'd1 || data_sel !== 7'b0000001) begin
      $display("FAIL post_reset_arb: hmaster=%0d data_sel=%b exp 1/0000001", hmaster, data_sel);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_incr_busy();
    test_locked();
    test_early_term();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
